data_mem_bytelane: RTL and testbench

- Parametrised successor to the pipeline's word-only data memory, sitting in the MEM stage.
- Byte-addressed, with byte/half/word stores via per-byte write enables.
- Loads are byte/half/word with sign or zero extension.
- Read is synchronous with one-cycle latency and a valid strobe; misaligned accesses are flagged and suppressed.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/data_mem_bytelane_if.sv | 26 ++
 rtl/dmem_lane_align.sv | 41 ++++
 rtl/data_mem_bytelane.sv | 97 +++++++++
 tb/tb_data_mem_bytelane.sv | 125 ++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared size encodings plus byte-enable and alignment helpers for the byte-lane data memory.
// Pure functions: no latency, no backpressure.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Enable for byte position idx of a word, given access size and starting lane.
  function automatic logic byte_en(input logic [1:0] size, input int lane, input int idx);
    logic en;
    en = 1'b0;
    case (size)
      SZ_BYTE: en = (idx == lane);
      SZ_HALF: en = (idx == lane) || (idx == lane + 1);
      SZ_WORD: en = 1'b1;
      default: en = 1'b0;
    endcase
    return en;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input int lane);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (lane[0] == 1'b0);
      SZ_WORD: ok = (lane == 0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_bytelane_if.sv
// Load/store request and response bundle for the byte-lane data memory.
// Single-cycle request, one-cycle registered response; no backpressure.
interface data_mem_bytelane_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              rd;
  logic              wr;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              misalign;

  modport master (
    output rd, wr, size, unsigned_ld, addr, data_in,
    input  data_out, rd_valid, misalign
  );

  modport slave (
    input  rd, wr, size, unsigned_ld, addr, data_in,
    output data_out, rd_valid, misalign
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: replicates store data into all lanes, extracts and extends load data.
// Zero latency, no backpressure; also intended for the cache data path.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LANE_W = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic [LANE_W-1:0] lane,
  input  logic              unsigned_ld,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_repl,
  input  logic [DATA_W-1:0] ld_word,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = ld_word >> {lane, 3'b000};
    st_repl = st_data;
    ld_data = shifted;
    case (size)
      SZ_BYTE: begin
        st_repl = {NB{st_data[7:0]}};
        ld_data = {{(DATA_W-8){~unsigned_ld & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        st_repl = {(NB/2){st_data[15:0]}};
        ld_data = {{(DATA_W-16){~unsigned_ld & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        st_repl = st_data;
        ld_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_bytelane.sv
// Byte-addressed MEM-stage data memory with byte/half/word access; loads registered, 1-cycle latency, no backpressure.
// DMEM_WR_BYPASS_EN makes a same-cycle load+store to one word return the merged (write-first) data.
module data_mem_bytelane
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               rst,
  data_mem_bytelane_if.slave bus
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] lane;
  logic              legal;
  logic              st_ok;
  logic              ld_ok;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] ld_word;
  logic [DATA_W-1:0] st_repl;
  logic [DATA_W-1:0] ld_data;

  // Upper address bits are ignored so the array wraps modulo DEPTH words.
  wire unused_addr_hi = ^bus.addr[ADDR_W-1:IDX_W+LANE_W];

  assign idx      = bus.addr[IDX_W+LANE_W-1:LANE_W];
  assign lane     = bus.addr[LANE_W-1:0];
  assign legal    = is_aligned(bus.size, 32'(lane));
  assign st_ok    = bus.wr & legal;
  assign ld_ok    = bus.rd & legal;
  assign old_word = mem[idx];

  always_comb begin
    be          = '0;
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      be[i] = byte_en(bus.size, 32'(lane), i);
      if (be[i]) begin
        merged_word[i*8 +: 8] = st_repl[i*8 +: 8];
      end
    end
  end

`ifdef DMEM_WR_BYPASS_EN
  assign ld_word = st_ok ? merged_word : old_word;
`else
  assign ld_word = old_word;
`endif

  dmem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size        (bus.size),
    .lane        (lane),
    .unsigned_ld (bus.unsigned_ld),
    .st_data     (bus.data_in),
    .st_repl     (st_repl),
    .ld_word     (ld_word),
    .ld_data     (ld_data)
  );

  // Array carries no reset; a store is simply suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && st_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= st_repl[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
      bus.misalign <= 1'b0;
    end else begin
      bus.rd_valid <= ld_ok;
      bus.misalign <= (bus.rd | bus.wr) & ~legal;
      if (ld_ok) begin
        bus.data_out <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed bench for data_mem_bytelane: hand-computed loads/stores, alignment, bypass, wrap and async reset.
module tb_data_mem_bytelane;
  import dmem_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  data_mem_bytelane_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  data_mem_bytelane #(
    .DATA_W (32),
    .DEPTH  (1024),
    .ADDR_W (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DMEM_WR_BYPASS_EN
  localparam logic [31:0] EXP_RW_WORD = 32'h2222_2222;
  localparam logic [31:0] EXP_RW_BYTE = 32'hFFFF_FFAB;
`else
  localparam logic [31:0] EXP_RW_WORD = 32'h1111_1111;
  localparam logic [31:0] EXP_RW_BYTE = 32'h0000_0022;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic v, input logic m);
    chk({tag, ".data_out"}, bus.data_out, d);
    chk({tag, ".rd_valid"}, {31'd0, bus.rd_valid}, {31'd0, v});
    chk({tag, ".misalign"}, {31'd0, bus.misalign}, {31'd0, m});
  endtask

  task automatic op(input logic r, input logic w, input logic [1:0] sz, input logic u,
                    input logic [31:0] a, input logic [31:0] d);
    bus.rd          = r;
    bus.wr          = w;
    bus.size        = sz;
    bus.unsigned_ld = u;
    bus.addr        = a;
    bus.data_in     = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.rd          = 1'b0;
    bus.wr          = 1'b0;
    bus.size        = SZ_WORD;
    bus.unsigned_ld = 1'b0;
    bus.addr        = '0;
    bus.data_in     = '0;

    #12;
    chk_out("reset", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    op(0, 1, SZ_WORD, 0, 32'h10, 32'hDEAD_BEEF);  chk_out("st_word",   32'h0000_0000, 0, 0);
    op(1, 0, SZ_WORD, 0, 32'h10, 32'h0);          chk_out("ld_word",   32'hDEAD_BEEF, 1, 0);
    op(0, 1, SZ_BYTE, 0, 32'h11, 32'h7F);         chk_out("st_byte",   32'hDEAD_BEEF, 0, 0);
    op(1, 0, SZ_WORD, 0, 32'h10, 32'h0);          chk_out("ld_merge",  32'hDEAD_7FEF, 1, 0);
    op(1, 0, SZ_BYTE, 0, 32'h13, 32'h0);          chk_out("ld_sb",     32'hFFFF_FFDE, 1, 0);
    op(1, 0, SZ_BYTE, 1, 32'h13, 32'h0);          chk_out("ld_ub",     32'h0000_00DE, 1, 0);
    op(1, 0, SZ_BYTE, 0, 32'h11, 32'h0);          chk_out("ld_sb_pos", 32'h0000_007F, 1, 0);
    op(0, 1, SZ_HALF, 0, 32'h22, 32'h8001);       chk_out("st_half",   32'h0000_007F, 0, 0);
    op(1, 0, SZ_HALF, 0, 32'h22, 32'h0);          chk_out("ld_sh",     32'hFFFF_8001, 1, 0);
    op(1, 0, SZ_HALF, 1, 32'h22, 32'h0);          chk_out("ld_uh",     32'h0000_8001, 1, 0);
    op(1, 0, SZ_HALF, 0, 32'h21, 32'h0);          chk_out("mis_ldh",   32'h0000_8001, 0, 1);
    op(0, 1, SZ_WORD, 0, 32'h22, 32'h1234_5678);  chk_out("mis_stw",   32'h0000_8001, 0, 1);
    op(1, 0, 2'b11,   0, 32'h00, 32'h0);          chk_out("mis_rsvd",  32'h0000_8001, 0, 1);
    op(1, 0, SZ_HALF, 1, 32'h22, 32'h0);          chk_out("ld_uh_kept",32'h0000_8001, 1, 0);

    op(0, 1, SZ_WORD, 0, 32'h30, 32'h1111_1111);  chk_out("st_30",     32'h0000_8001, 0, 0);
    op(1, 1, SZ_WORD, 0, 32'h30, 32'h2222_2222);  chk_out("rw_word",   EXP_RW_WORD,   1, 0);
    op(1, 0, SZ_WORD, 0, 32'h30, 32'h0);          chk_out("ld_after",  32'h2222_2222, 1, 0);
    op(1, 1, SZ_BYTE, 0, 32'h31, 32'hAB);         chk_out("rw_byte",   EXP_RW_BYTE,   1, 0);
    op(1, 0, SZ_WORD, 0, 32'h30, 32'h0);          chk_out("ld_after_b",32'h2222_AB22, 1, 0);

    op(0, 1, SZ_WORD, 0, 32'h1004, 32'hCAFE_F00D); chk_out("st_wrap",  32'h2222_AB22, 0, 0);
    op(1, 0, SZ_WORD, 0, 32'h0004, 32'h0);         chk_out("ld_wrap",  32'hCAFE_F00D, 1, 0);
    op(1, 0, SZ_WORD, 0, 32'h10, 32'h0);           chk_out("b2b_1",    32'hDEAD_7FEF, 1, 0);
    op(1, 0, SZ_WORD, 0, 32'h30, 32'h0);           chk_out("b2b_2",    32'h2222_AB22, 1, 0);

    // Mid-cycle reset with a load burst and a store held active.
    #3;
    rst         = 1'b1;
    bus.wr      = 1'b1;
    bus.size    = SZ_WORD;
    bus.addr    = 32'h10;
    bus.data_in = 32'h5555_5555;
    #1;
    chk_out("rst_async", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_out("rst_held", 32'h0, 1'b0, 1'b0);
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    op(1, 0, SZ_WORD, 0, 32'h10, 32'h0);           chk_out("ld_post_rst", 32'hDEAD_7FEF, 1, 0);
    op(0, 0, SZ_WORD, 0, 32'h10, 32'h0);           chk_out("idle_hold",   32'hDEAD_7FEF, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
